// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared op encodings, FSM state type and counter sizing for div_unit
// Rev 1.0
// ============================================================================
`default_nettype none

package div_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one combinational restoring-division step on unsigned magnitudes
// Rev 1.0
// ============================================================================
`default_nettype none

module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             quo_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem_in < divisor always holds, so the shifted value fits in WIDTH+1 bits
   // and whichever branch is taken fits back into WIDTH bits.
   assign shifted = {rem_in, quo_msb};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = (shifted >= {1'b0, divisor});
   assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// div_unit : iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// Option DIV_ZERO_FASTPATH_EN: zero divisor bypasses the iteration phase.
// Rev 1.0
// ============================================================================
`default_nettype none

module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             busy
);

   localparam int           CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef DIV_ZERO_FASTPATH_EN
   localparam bit FAST_DZ = 1'b1;
`else
   localparam bit FAST_DZ = 1'b0;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       op;
   logic             sign_q;
   logic             sign_r;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] result;
   logic [CW-1:0]    count;

   logic             accept;
   logic             is_signed;
   logic             b_zero;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] step_rem;
   logic             q_bit;

   assign is_signed = ~in_op[0];
   assign b_zero    = (in_b == '0);
   assign a_mag     = (is_signed && in_a[WIDTH-1]) ? -in_a : in_a;
   assign b_mag     = (is_signed && in_b[WIDTH-1]) ? -in_b : in_b;
   assign accept    = in_valid && (state == ST_IDLE) && !flush;

   assign in_ready   = (state == ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign out_valid  = (state == ST_DONE);
   assign out_result = result;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .quo_msb (quo[WIDTH-1]),
      .divisor (dvsr),
      .rem_out (step_rem),
      .q_bit   (q_bit)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = (FAST_DZ && b_zero) ? ST_FIX : ST_CALC;
         ST_CALC: if (count == LAST) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (flush) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // A zero divisor iterates to quo=all-ones, rem=|a|; suppressing the quotient
   // sign makes DIV return all-ones and the remainder sign-fix restore in_a.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op     <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         rem    <= '0;
         quo    <= '0;
         dvsr   <= '0;
         count  <= '0;
         result <= '0;
      end else if (!flush) begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op     <= in_op;
                  sign_q <= is_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]) && !b_zero;
                  sign_r <= is_signed && in_a[WIDTH-1];
                  dvsr   <= b_mag;
                  count  <= '0;
                  if (FAST_DZ && b_zero) begin
                     rem <= a_mag;
                     quo <= '1;
                  end else begin
                     rem <= '0;
                     quo <= a_mag;
                  end
               end
            end
            ST_CALC: begin
               rem   <= step_rem;
               quo   <= {quo[WIDTH-2:0], q_bit};
               count <= count + 1'b1;
            end
            ST_FIX: begin
               if (op[1]) result <= sign_r ? -rem : rem;
               else       result <= sign_q ? -quo : quo;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// tb_div_unit : directed self-checking bench for div_unit (WIDTH=32)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [1:0]  in_op;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef DIV_ZERO_FASTPATH_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif
   localparam int NLAT = 33;

   div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one request, measure edges from accept to out_valid, check the result.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = 32'hDEAD_BEEF; in_b = 32'h0; in_op = 2'b11;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, " result"}, out_result, exp);
      if (out_ready) begin
         @(posedge clk); #1;
         check_eq({tag, " idle after"}, {31'd0, in_ready}, 32'd1);
      end
   endtask

   initial begin
      int hits;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
      flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst in_ready",   {31'd0, in_ready},  32'd1);
      check_eq("rst out_valid",  {31'd0, out_valid}, 32'd0);
      check_eq("rst busy",       {31'd0, busy},      32'd0);
      check_eq("rst out_result", out_result,         32'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op("divu 100/7",  2'b01, 32'd100,      32'd7,        32'd14,       NLAT);
      run_op("remu 100/7",  2'b11, 32'd100,      32'd7,        32'd2,        NLAT);
      run_op("div -7/2",    2'b00, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NLAT);
      run_op("rem -7/2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NLAT);
      run_op("rem 7/-2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        NLAT);
      run_op("div -7/-2",   2'b00, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        NLAT);
      run_op("div ovf",     2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, NLAT);
      run_op("rem ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        NLAT);
      run_op("divu big",    2'b01, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, NLAT);
      run_op("div 5/0",     2'b00, 32'd5,        32'd0,        32'hFFFFFFFF, ZLAT);
      run_op("rem -5/0",    2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, ZLAT);
      run_op("div -5/0",    2'b00, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, ZLAT);
      run_op("remu big/0",  2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, ZLAT);

      // Backpressure: result must hold while the consumer stalls.
      out_ready = 1'b0;
      run_op("stall divu",  2'b01, 32'd100,      32'd7,        32'd14,       NLAT);
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd9; in_b = 32'd3; in_op = 2'b01;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check_eq("stall out_valid", {31'd0, out_valid}, 32'd1);
         check_eq("stall result",    out_result,         32'd14);
         check_eq("stall in_ready",  {31'd0, in_ready},  32'd0);
      end
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      check_eq("release out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("release no accept", {31'd0, busy},      32'd0);
      in_valid = 1'b0;

      // Flush mid-calculation.
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd100; in_b = 32'd7; in_op = 2'b01;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check_eq("flush in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("flush busy",     {31'd0, busy},     32'd0);

      // Flush in IDLE blocks an accept.
      @(negedge clk); in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
      check_eq("idle flush busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-calculation.
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'd50; in_b = 32'd5; in_op = 2'b01;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #2;
      check_eq("async rst in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("async rst result",   out_result,         32'd0);
      #1 rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) hits++;
      end
      check_eq("no stray out_valid", 32'(hits), 32'd0);

      run_op("post rst div", 2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, NLAT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
